regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (reg_write, rd, write_data) between two writeback requesters: A = ALU result path, B = load/memory return path.
- Uses round-robin arbitration with valid/ready handshakes and a registered write stage.
- Keeps a per-register busy scoreboard so the decode stage can stall on read-after-write hazards against the combinational read ports.

---
 rtl/regfile_wb_arbiter_if.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, hazard check and register-file write signals
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NREG = 2 ** ADDR_W;

  // Requester A (ALU result path)
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;

  // Requester B (load/memory return path)
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;

  // Issue-side scoreboard claim and decode-side hazard check
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic [ADDR_W-1:0] chk_rs1;
  logic [ADDR_W-1:0] chk_rs2;
  logic              hazard;

  // Register file write port
  logic              reg_write;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] write_data;
  logic [NREG-1:0]   busy;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  issue_valid, issue_rd, chk_rs1, chk_rs2,
    output a_ready, b_ready, hazard,
    output reg_write, rd, write_data, busy
  );

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output issue_valid, issue_rd, chk_rs1, chk_rs2,
    input  a_ready, b_ready, hazard,
    input  reg_write, rd, write_data, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with busy scoreboard for one register-file write port
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic both_valid;
  logic a_ready, b_ready;
  logic a_fire, b_fire;
  logic hazard;

  // Arbitration: a lone requester (or nobody) sees ready; on conflict the one not granted last wins
  always_comb begin
    both_valid = bus.a_valid && bus.b_valid;
    a_ready    = !both_valid || (last_grant_q == GRANT_B);
    b_ready    = !both_valid || (last_grant_q == GRANT_A);
    a_fire     = bus.a_valid && a_ready;
    b_fire     = bus.b_valid && b_ready;
  end

  // Write stage next state: capture the winner; register 0 completes the handshake but never writes
  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    rd_d         = rd_q;
    data_d       = data_q;
    if (a_fire) begin
      last_grant_d = GRANT_A;
      reg_write_d  = (bus.a_rd != '0);
      rd_d         = bus.a_rd;
      data_d       = bus.a_data;
    end else if (b_fire) begin
      last_grant_d = GRANT_B;
      reg_write_d  = (bus.b_rd != '0);
      rd_d         = bus.b_rd;
      data_d       = bus.b_data;
    end
  end

  // Scoreboard next state: clear on commit, then set on issue so a newer producer overrides the clear
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Read-after-write hazard against the scoreboard only; the in-flight write stage is not bypassed
  always_comb begin
    hazard = ((bus.chk_rs1 != '0) && busy_q[bus.chk_rs1]) ||
             ((bus.chk_rs2 != '0) && busy_q[bus.chk_rs2]);
  end

  // State registers; reset drops any in-flight write and biases the first conflict toward A
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GRANT_B;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.a_ready    = a_ready;
  assign bus.b_ready    = b_ready;
  assign bus.hazard     = hazard;
  assign bus.reg_write  = reg_write_q;
  assign bus.rd         = rd_q;
  assign bus.write_data = data_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Register file model fed by the DUT write port
  always @(posedge clk) begin
    if (bus.reg_write) rf[bus.rd] <= bus.write_data;
  end

  // Monitor: every presented write must match the next expected write
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!reset && bus.reg_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual rd=%0d data=%0h required none", bus.rd, bus.write_data);
        end else begin
          w = exp_q.pop_front();
          check("wr_rd", 64'(bus.rd), 64'(w.rd));
          check("wr_data", 64'(bus.write_data), 64'(w.data));
        end
      end
    end
  end

  task automatic drive_a(input logic [4:0] rd, input logic [31:0] data);
    logic ok;
    ok = 1'b0;
    bus.a_rd    = rd;
    bus.a_data  = data;
    bus.a_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.a_ready;
      @(posedge clk);
      #1;
    end
    check("a_accept", 64'(ok), 64'd1);
    if (!ok) bus.a_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [4:0] rd, input logic [31:0] data);
    logic ok;
    ok = 1'b0;
    bus.b_rd    = rd;
    bus.b_data  = data;
    bus.b_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.b_ready;
      @(posedge clk);
      #1;
    end
    check("b_accept", 64'(ok), 64'd1);
    if (!ok) bus.b_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  initial begin
    logic seen;
    reset           = 1'b1;
    bus.a_valid     = 1'b0;
    bus.a_rd        = '0;
    bus.a_data      = '0;
    bus.b_valid     = 1'b0;
    bus.b_rd        = '0;
    bus.b_data      = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.chk_rs1     = '0;
    bus.chk_rs2     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and idle-ready
    @(negedge clk);
    check("rst_reg_write", 64'(bus.reg_write), 64'd0);
    check("rst_rd", 64'(bus.rd), 64'd0);
    check("rst_write_data", 64'(bus.write_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hazard", 64'(bus.hazard), 64'd0);
    check("idle_a_ready", 64'(bus.a_ready), 64'd1);
    check("idle_b_ready", 64'(bus.b_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single A write: one cycle of reg_write, then low with rd held
    push(5'd5, 32'hDEADBEEF);
    drive_a(5'd5, 32'hDEADBEEF);
    bus.a_valid = 1'b0;
    @(negedge clk);
    check("t2_reg_write_hi", 64'(bus.reg_write), 64'd1);
    @(negedge clk);
    check("t2_reg_write_lo", 64'(bus.reg_write), 64'd0);
    check("t2_rd_hold", 64'(bus.rd), 64'd5);
    @(posedge clk);
    #1;

    // Reset mid-stream with a pending write
    issue(5'd20);
    @(negedge clk);
    check("t1_busy20_set", 64'(bus.busy[20]), 64'd1);
    @(posedge clk);
    #1;
    drive_a(5'd3, 32'h00000333);
    bus.a_valid = 1'b0;
    check("t1_pending", 64'(bus.reg_write), 64'd1);
    reset = 1'b1;
    #1;
    check("t1_reg_write_drop", 64'(bus.reg_write), 64'd0);
    check("t1_busy_clear", 64'(bus.busy), 64'd0);
    check("t1_rd_clear", 64'(bus.rd), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Both requesters streaming: A wins first after reset, then strict alternation
    for (int i = 1; i <= 4; i++) begin
      push(5'(i), 32'hA0000000 + 32'(i));
      push(5'(i + 10), 32'hB0000000 + 32'(i + 10));
    end
    fork
      begin
        for (int i = 1; i <= 4; i++) drive_a(5'(i), 32'hA0000000 + 32'(i));
        bus.a_valid = 1'b0;
      end
      begin
        for (int j = 11; j <= 14; j++) drive_b(5'(j), 32'hB0000000 + 32'(j));
        bus.b_valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          seen = bus.reg_write;
        end
        check("t3_start", 64'(seen), 64'd1);
        for (int k = 0; k < 7; k++) begin
          @(negedge clk);
          check("t3_continuous", 64'(bus.reg_write), 64'd1);
        end
      end
    join
    @(posedge clk);
    #1;

    // Register 0: handshake completes, no write, no busy, no hazard
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd0;
    bus.chk_rs1     = 5'd0;
    bus.chk_rs2     = 5'd0;
    drive_a(5'd0, 32'h00000123);
    bus.a_valid     = 1'b0;
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("t6_reg_write", 64'(bus.reg_write), 64'd0);
    check("t6_busy0", 64'(bus.busy[0]), 64'd0);
    check("t6_hazard", 64'(bus.hazard), 64'd0);
    @(posedge clk);
    #1;

    // The rd=0 transfer counted as an A grant, so B wins the next conflict
    push(5'd12, 32'h0000BB12);
    push(5'd2, 32'h0000AA02);
    fork
      begin
        drive_a(5'd2, 32'h0000AA02);
        bus.a_valid = 1'b0;
      end
      begin
        drive_b(5'd12, 32'h0000BB12);
        bus.b_valid = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // RAW hazard on r7 cleared by a B write
    issue(5'd7);
    bus.chk_rs1 = 5'd7;
    @(negedge clk);
    check("t4_hazard_set", 64'(bus.hazard), 64'd1);
    @(posedge clk);
    #1;
    push(5'd7, 32'hCAFE0007);
    drive_b(5'd7, 32'hCAFE0007);
    bus.b_valid = 1'b0;
    @(negedge clk);
    check("t4_wr_cycle_reg_write", 64'(bus.reg_write), 64'd1);
    check("t4_wr_cycle_hazard", 64'(bus.hazard), 64'd1);
    @(negedge clk);
    check("t4_hazard_clear", 64'(bus.hazard), 64'd0);
    check("t4_rf_value", 64'(rf[7]), 64'hCAFE0007);
    @(posedge clk);
    #1;
    bus.chk_rs1 = 5'd0;

    // Set and clear of r9 on the same edge: set wins
    issue(5'd9);
    @(negedge clk);
    check("t5_busy9_set", 64'(bus.busy[9]), 64'd1);
    @(posedge clk);
    #1;
    push(5'd9, 32'h99990001);
    drive_a(5'd9, 32'h99990001);
    bus.a_valid = 1'b0;
    issue(5'd9);
    bus.chk_rs2 = 5'd9;
    @(negedge clk);
    check("t5_busy9_kept", 64'(bus.busy[9]), 64'd1);
    check("t5_hazard_rs2", 64'(bus.hazard), 64'd1);
    @(posedge clk);
    #1;
    push(5'd9, 32'h99990002);
    drive_a(5'd9, 32'h99990002);
    bus.a_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_busy9_clear", 64'(bus.busy[9]), 64'd0);
    check("t5_hazard_clear", 64'(bus.hazard), 64'd0);

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
